// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH radix-3 DIT butterfly.
// Latency: n/a (package only).
// Backpressure: n/a.
package prach_pkg;

    // Sample width of the real/imag data buses.
    localparam int DW = 18;

    // sqrt(3)/2 in Q1.17.
    localparam int SQRT3_HALF_Q17 = 113512;

    // Fraction bits of the constant. Accumulators hold Xk scaled by 2^FRAC.
    localparam int FRAC = 17;

    // Accumulator width. The largest magnitude is about 2^36, so 40 bits leave headroom.
    localparam int ACC_W = 40;

    typedef logic signed [DW-1:0]    smp_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        smp_t re;
        smp_t im;
    } cplx_t;

    typedef struct packed {
        acc_t re;
        acc_t im;
    } cacc_t;

    // Position of the next expected input sample within a group.
    typedef enum logic [1:0] {
        PH_X0 = 2'd0,
        PH_S  = 2'd1,
        PH_D  = 2'd2
    } phase_e;

    // Output burst sequencer.
    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_X0   = 2'd1,
        B_X1   = 2'd2,
        B_X2   = 2'd3
    } burst_e;

endpackage

// File: rtl/prach_ditfft3_bf2_if.sv
// Sample-stream bundle for the radix-3 butterfly: an input stream and an output stream.
// Latency: n/a (wiring only).
// Backpressure: none; both streams are valid-only.
// Ports: din_dr/din_di/din_dv/sync_in carry samples into the butterfly.
//        dout_dr/dout_di/dout_dv/sync_out carry results out of it.
// Modports: slave is the butterfly side; master is the source/sink side.
interface prach_ditfft3_bf2_if;
    import prach_pkg::*;

    smp_t din_dr;
    smp_t din_di;
    logic din_dv;
    logic sync_in;

    smp_t dout_dr;
    smp_t dout_di;
    logic dout_dv;
    logic sync_out;

    modport slave (
        input  din_dr, din_di, din_dv, sync_in,
        output dout_dr, dout_di, dout_dv, sync_out
    );

    modport master (
        output din_dr, din_di, din_dv, sync_in,
        input  dout_dr, dout_di, dout_dv, sync_out
    );

endinterface

// File: rtl/prach_ditfft3_rndsat.sv
// Reduces an accumulator holding Xk*2^17 to Xk/2 as an 18-bit integer, then saturates it.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: acc_i is the full-precision value; dat_o is the saturated sample.
// PRACH_DITFFT3_BF2_ROUND_EN defined selects round half up; otherwise the value is floored.
module prach_ditfft3_rndsat
    import prach_pkg::*;
(
    input  acc_t acc_i,
    output smp_t dat_o
);

    localparam acc_t SAT_MAX = acc_t'((1 <<< (DW - 1)) - 1);
    localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);

    acc_t biased;
    acc_t scaled;

`ifdef PRACH_DITFFT3_BF2_ROUND_EN
    // Half an output LSB. One output LSB is 2^(FRAC+1), because of the /2 scaling.
    localparam acc_t HALF_LSB = acc_t'(1) <<< FRAC;
    assign biased = acc_i + HALF_LSB;
`else
    assign biased = acc_i;
`endif

    // An arithmetic shift floors toward minus infinity.
    assign scaled = biased >>> (FRAC + 1);

    always_comb begin
        dat_o = scaled[DW-1:0];
        if (scaled > SAT_MAX) begin
            dat_o = SAT_MAX[DW-1:0];
        end else if (scaled < SAT_MIN) begin
            dat_o = SAT_MIN[DW-1:0];
        end
    end

endmodule

// File: rtl/prach_ditfft3_bf2.sv
// Radix-3 DIT butterfly. Input groups are x0, s=x1+x2, d=x2-x1; the outputs are X0, X1, X2, each scaled by 1/2.
// Latency: X0 appears 4 cycles after d is accepted, and X1 and X2 follow on the next two cycles.
// Backpressure: none; groups arrive at least 3 cycles apart, so output bursts never overlap.
// Ports: clk, rst_n (synchronous, active-low); io is the sample-stream bundle (slave side).
// Parameter INVERSE: 0 selects the forward twiddle; 1 selects the conjugate twiddle.
// Macro PRACH_DITFFT3_BF2_ROUND_EN: defined gives round half up, undefined gives floor (see rndsat).
module prach_ditfft3_bf2
    import prach_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    prach_ditfft3_bf2_if.slave  io
);

    localparam acc_t C_Q17 = acc_t'(SQRT3_HALF_Q17);

    cplx_t din;
    assign din.re = io.din_dr;
    assign din.im = io.din_di;

    // ---------------- group assembly ----------------
    phase_e phase_q, phase_d;
    cplx_t  x0_q, x0_d;
    cplx_t  s_q, s_d;
    logic   sync_pend_q, sync_pend_d;

    logic   a_vld_q, a_vld_d;
    logic   a_sync_q, a_sync_d;
    cplx_t  a_x0_q, a_x0_d;
    cplx_t  a_s_q, a_s_d;
    cplx_t  a_dif_q, a_dif_d;

    always_comb begin
        phase_d     = phase_q;
        x0_d        = x0_q;
        s_d         = s_q;
        sync_pend_d = sync_pend_q;
        a_vld_d     = 1'b0;
        a_sync_d    = 1'b0;
        a_x0_d      = a_x0_q;
        a_s_d       = a_s_q;
        a_dif_d     = a_dif_q;
        if (io.din_dv) begin
            // A sync restarts the group, which drops any partial group already collected.
            if (io.sync_in || phase_q == PH_X0) begin
                x0_d        = din;
                sync_pend_d = io.sync_in;
                phase_d     = PH_S;
            end else if (phase_q == PH_S) begin
                s_d     = din;
                phase_d = PH_D;
            end else begin
                a_vld_d  = 1'b1;
                a_sync_d = sync_pend_q;
                a_x0_d   = x0_q;
                a_s_d    = s_q;
                a_dif_d  = din;
                phase_d  = PH_X0;
            end
        end
    end

    // ---------------- butterfly arithmetic (values scaled by 2^FRAC) ----------------
    logic  b_vld_q, b_vld_d;
    logic  b_sync_q, b_sync_d;
    cacc_t b_x0_q, b_x0_d;
    cacc_t b_x1_q, b_x1_d;
    cacc_t b_x2_q, b_x2_d;

    acc_t x0r, x0i, sr, si, dr, di;
    acc_t cdr, cdi, hr, hi;

    always_comb begin
        x0r = acc_t'(a_x0_q.re);
        x0i = acc_t'(a_x0_q.im);
        sr  = acc_t'(a_s_q.re);
        si  = acc_t'(a_s_q.im);
        dr  = acc_t'(a_dif_q.re);
        di  = acc_t'(a_dif_q.im);
        cdr = dr * C_Q17;
        cdi = di * C_Q17;
        // This is x0 - s/2, aligned to the Q17 product scale.
        hr  = (x0r <<< FRAC) - (sr <<< (FRAC - 1));
        hi  = (x0i <<< FRAC) - (si <<< (FRAC - 1));

        b_vld_d   = a_vld_q;
        b_sync_d  = a_sync_q;
        b_x0_d.re = (x0r + sr) <<< FRAC;
        b_x0_d.im = (x0i + si) <<< FRAC;
        if (INVERSE == 1'b0) begin
            b_x1_d.re = hr - cdi;
            b_x1_d.im = hi + cdr;
            b_x2_d.re = hr + cdi;
            b_x2_d.im = hi - cdr;
        end else begin
            b_x1_d.re = hr + cdi;
            b_x1_d.im = hi - cdr;
            b_x2_d.re = hr - cdi;
            b_x2_d.im = hi + cdr;
        end
    end

    // ---------------- result hold and output burst ----------------
    burst_e state_q, state_d;
    cacc_t  h_x0_q, h_x0_d;
    cacc_t  h_x1_q, h_x1_d;
    cacc_t  h_x2_q, h_x2_d;
    logic   h_sync_q, h_sync_d;

    smp_t   dout_dr_q, dout_dr_d;
    smp_t   dout_di_q, dout_di_d;
    logic   dout_dv_q, dout_dv_d;
    logic   sync_out_q, sync_out_d;

    cacc_t  sel_acc;
    smp_t   rs_re, rs_im;

    always_comb begin
        state_d    = state_q;
        h_x0_d     = h_x0_q;
        h_x1_d     = h_x1_q;
        h_x2_d     = h_x2_q;
        h_sync_d   = h_sync_q;
        sel_acc    = h_x0_q;
        dout_dr_d  = dout_dr_q;
        dout_di_d  = dout_di_q;
        dout_dv_d  = 1'b0;
        sync_out_d = 1'b0;

        case (state_q)
            B_X0: begin
                sel_acc    = h_x0_q;
                dout_dv_d  = 1'b1;
                sync_out_d = h_sync_q;
                state_d    = B_X1;
            end
            B_X1: begin
                sel_acc   = h_x1_q;
                dout_dv_d = 1'b1;
                state_d   = B_X2;
            end
            B_X2: begin
                sel_acc   = h_x2_q;
                dout_dv_d = 1'b1;
                state_d   = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase

        if (dout_dv_d) begin
            dout_dr_d = rs_re;
            dout_di_d = rs_im;
        end

        // A new group can land during the X2 cycle at the earliest. The hold registers are
        // read before this edge, so reloading them here is safe.
        if (b_vld_q) begin
            h_x0_d   = b_x0_q;
            h_x1_d   = b_x1_q;
            h_x2_d   = b_x2_q;
            h_sync_d = b_sync_q;
            state_d  = B_X0;
        end
    end

    prach_ditfft3_rndsat u_rndsat_re (
        .acc_i (sel_acc.re),
        .dat_o (rs_re)
    );

    prach_ditfft3_rndsat u_rndsat_im (
        .acc_i (sel_acc.im),
        .dat_o (rs_im)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= PH_X0;
            x0_q        <= '0;
            s_q         <= '0;
            sync_pend_q <= 1'b0;
            a_vld_q     <= 1'b0;
            a_sync_q    <= 1'b0;
            a_x0_q      <= '0;
            a_s_q       <= '0;
            a_dif_q     <= '0;
            b_vld_q     <= 1'b0;
            b_sync_q    <= 1'b0;
            b_x0_q      <= '0;
            b_x1_q      <= '0;
            b_x2_q      <= '0;
            state_q     <= B_IDLE;
            h_x0_q      <= '0;
            h_x1_q      <= '0;
            h_x2_q      <= '0;
            h_sync_q    <= 1'b0;
            dout_dr_q   <= '0;
            dout_di_q   <= '0;
            dout_dv_q   <= 1'b0;
            sync_out_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            x0_q        <= x0_d;
            s_q         <= s_d;
            sync_pend_q <= sync_pend_d;
            a_vld_q     <= a_vld_d;
            a_sync_q    <= a_sync_d;
            a_x0_q      <= a_x0_d;
            a_s_q       <= a_s_d;
            a_dif_q     <= a_dif_d;
            b_vld_q     <= b_vld_d;
            b_sync_q    <= b_sync_d;
            b_x0_q      <= b_x0_d;
            b_x1_q      <= b_x1_d;
            b_x2_q      <= b_x2_d;
            state_q     <= state_d;
            h_x0_q      <= h_x0_d;
            h_x1_q      <= h_x1_d;
            h_x2_q      <= h_x2_d;
            h_sync_q    <= h_sync_d;
            dout_dr_q   <= dout_dr_d;
            dout_di_q   <= dout_di_d;
            dout_dv_q   <= dout_dv_d;
            sync_out_q  <= sync_out_d;
        end
    end

    assign io.dout_dr  = dout_dr_q;
    assign io.dout_di  = dout_di_q;
    assign io.dout_dv  = dout_dv_q;
    assign io.sync_out = sync_out_q;

endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// Bench for prach_ditfft3_bf2: forward and inverse instances share one directed stimulus stream.
// Expected outputs come from an arithmetic model of the butterfly equations, keyed by cycle.
module tb_prach_ditfft3_bf2;

    localparam int NCYC = 1024;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    bit   cmp_en = 0;
    bit   rst_seen = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    bit exp_dv [2][NCYC];
    bit exp_sy [2][NCYC];
    int exp_r  [2][NCYC];
    int exp_i  [2][NCYC];
    int last_r [2];
    int last_i [2];

    prach_ditfft3_bf2_if fwd_if ();
    prach_ditfft3_bf2_if inv_if ();

    prach_ditfft3_bf2 #(.INVERSE(1'b0)) dut_fwd (.clk(clk), .rst_n(rst_n), .io(fwd_if));
    prach_ditfft3_bf2 #(.INVERSE(1'b1)) dut_inv (.clk(clk), .rst_n(rst_n), .io(inv_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    // The butterfly equations evaluated directly, followed by /2, reduction and saturation.
    function automatic int xval(int k, bit im, bit inv, int x0r, int x0i, int sr, int si, int dr, int di);
        longint v;
        longint t;
        longint c = 113512;
        int     sg;
        if (k == 0) begin
            v = longint'(im ? (x0i + si) : (x0r + sr)) * 131072;
        end else begin
            sg = (k == 1) ? 1 : -1;
            if (inv) sg = -sg;
            if (!im) v = longint'(x0r) * 131072 - longint'(sr) * 65536 - sg * c * longint'(di);
            else     v = longint'(x0i) * 131072 - longint'(si) * 65536 + sg * c * longint'(dr);
        end
`ifdef PRACH_DITFFT3_BF2_ROUND_EN
        t = (v + 131072) >>> 18;
`else
        t = v >>> 18;
`endif
        if (t > 131071)  t = 131071;
        if (t < -131072) t = -131072;
        return int'(t);
    endfunction

    task automatic chk(string nm, int act, int ex);
        n_cmp++;
        if (act != ex) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
        end
    endtask

    task automatic set_in(int dr, int di, bit dv, bit sy);
        logic signed [17:0] r18;
        logic signed [17:0] i18;
        r18 = dr[17:0];
        i18 = di[17:0];
        fwd_if.din_dr  = r18;
        fwd_if.din_di  = i18;
        fwd_if.din_dv  = dv;
        fwd_if.sync_in = sy;
        inv_if.din_dr  = r18;
        inv_if.din_di  = i18;
        inv_if.din_dv  = dv;
        inv_if.sync_in = sy;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int dr, int di, bit sy);
        set_in(dr, di, 1'b1, sy);
        @(posedge clk);
        #1;
        set_in(0, 0, 1'b0, 1'b0);
    endtask

    task automatic put_group(int dc, int x0r, int x0i, int sr, int si, int dr, int di, bit sy);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                exp_dv[d][dc + 4 + k] = 1'b1;
                exp_sy[d][dc + 4 + k] = (k == 0) && sy;
                exp_r[d][dc + 4 + k]  = xval(k, 1'b0, d[0], x0r, x0i, sr, si, dr, di);
                exp_i[d][dc + 4 + k]  = xval(k, 1'b1, d[0], x0r, x0i, sr, si, dr, di);
            end
        end
    endtask

    task automatic group(int x0r, int x0i, int sr, int si, int dr, int di, bit sy, int gap);
        int dc;
        send(x0r, x0i, sy);
        idle(gap);
        send(sr, si, 1'b0);
        idle(gap);
        dc = cyc;
        send(dr, di, 1'b0);
        put_group(dc, x0r, x0i, sr, si, dr, di, sy);
    endtask

    // A reset discards everything in flight, so no output is expected after it.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = cyc; k < NCYC; k++) begin
            exp_dv[0][k] = 1'b0;
            exp_dv[1][k] = 1'b0;
        end
    endtask

    // Per-cycle check of both instances against the model table.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                int    ar, ai, adv, asy;
                string tg;
                tg = (d == 0) ? "fwd" : "inv";
                if (d == 0) begin
                    ar = fwd_if.dout_dr; ai = fwd_if.dout_di;
                    adv = int'(fwd_if.dout_dv); asy = int'(fwd_if.sync_out);
                end else begin
                    ar = inv_if.dout_dr; ai = inv_if.dout_di;
                    adv = int'(inv_if.dout_dv); asy = int'(inv_if.sync_out);
                end
                if (rst_seen) begin
                    last_r[d] = 0;
                    last_i[d] = 0;
                    chk($sformatf("%s rst dv c%0d", tg, cyc), adv, 0);
                    chk($sformatf("%s rst sync c%0d", tg, cyc), asy, 0);
                    chk($sformatf("%s rst dr c%0d", tg, cyc), ar, 0);
                    chk($sformatf("%s rst di c%0d", tg, cyc), ai, 0);
                end else if (exp_dv[d][cyc]) begin
                    last_r[d] = exp_r[d][cyc];
                    last_i[d] = exp_i[d][cyc];
                    chk($sformatf("%s dv c%0d", tg, cyc), adv, 1);
                    chk($sformatf("%s sync c%0d", tg, cyc), asy, int'(exp_sy[d][cyc]));
                    chk($sformatf("%s dr c%0d", tg, cyc), ar, exp_r[d][cyc]);
                    chk($sformatf("%s di c%0d", tg, cyc), ai, exp_i[d][cyc]);
                end else begin
                    chk($sformatf("%s idle dv c%0d", tg, cyc), adv, 0);
                    chk($sformatf("%s idle sync c%0d", tg, cyc), asy, 0);
                    chk($sformatf("%s hold dr c%0d", tg, cyc), ar, last_r[d]);
                    chk($sformatf("%s hold di c%0d", tg, cyc), ai, last_i[d]);
                end
            end
        end
    end

    initial begin
        int dc;
        rst_n = 1'b0;
        set_in(0, 0, 1'b0, 1'b0);

        // Hand-computed values that pin the model.
        chk("model X0 of 1000", xval(0, 1'b0, 1'b0, 1000, 0, 0, 0, 0, 0), 500);
        chk("model X1r of 1000", xval(1, 1'b0, 1'b0, 1000, 0, 0, 0, 0, 0), 500);
        chk("model X0 of s2000", xval(0, 1'b0, 1'b0, 0, 0, 2000, 0, 0, 0), 1000);
        chk("model X2r of s2000", xval(2, 1'b0, 1'b0, 0, 0, 2000, 0, 0, 0), -500);
`ifdef PRACH_DITFFT3_BF2_ROUND_EN
        chk("model X1r d=j1000", xval(1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1000), -433);
        chk("model inv X2r d=j1000", xval(2, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1000), -433);
`else
        chk("model X1r d=j1000", xval(1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1000), -434);
        chk("model inv X2r d=j1000", xval(2, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1000), -434);
`endif
        chk("model X2r d=j1000", xval(2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1000), 433);
        chk("model inv X1r d=j1000", xval(1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1000), 433);
        chk("model sat X1r", xval(1, 1'b0, 1'b0, 131071, 0, -131072, 0, 0, -131072), 131071);

        @(posedge clk);
        #1;
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic groups, with and without gaps.
        group(1000, 0, 0, 0, 0, 0, 1'b0, 0);
        idle(6);
        group(0, 0, 2000, 0, 0, 0, 1'b0, 0);
        idle(6);
        group(0, 0, 0, 0, 0, 1000, 1'b0, 1);
        idle(6);
        group(131071, 0, -131072, 0, 0, -131072, 1'b0, 0);
        idle(6);
        group(0, -131072, 0, 131071, 131071, 0, 1'b0, 0);
        idle(6);
        group(12345, -2222, -5000, 700, 3333, -4444, 1'b1, 2);
        idle(6);

        // Back-to-back groups: the second d arrives 3 cycles after the first.
        group(-7000, 8000, 4000, -3000, 2500, 6100, 1'b0, 0);
        group(60000, -60000, -90000, 90000, 70000, -80000, 1'b1, 0);
        idle(8);

        // A sync asserted without din_dv is ignored.
        send(500, -300, 1'b0);
        set_in(777, 777, 1'b0, 1'b1);
        idle(1);
        set_in(0, 0, 1'b0, 1'b0);
        send(1200, 40, 1'b0);
        dc = cyc;
        send(-60, 900, 1'b0);
        put_group(dc, 500, -300, 1200, 40, -60, 900, 1'b0);
        idle(6);

        // A partial group is discarded when a sync restarts the group.
        send(100, 100, 1'b0);
        send(200, 200, 1'b0);
        idle(2);
        group(3000, -1000, 500, 200, -700, 900, 1'b1, 1);
        idle(8);

        // Reset between samples of a group, then a clean group.
        send(9999, 1, 1'b0);
        send(5, 5, 1'b0);
        pulse_reset();
        idle(1);
        group(-4000, 2500, 1500, -1500, 800, -600, 1'b0, 0);
        idle(8);

        // Reset in the middle of a burst (after X0), then recovery.
        group(20000, -20000, 30000, 10000, -50000, 40000, 1'b0, 0);
        idle(3);
        pulse_reset();
        idle(3);
        group(111, 222, 333, 444, 555, 666, 1'b1, 0);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
